// File: rtl/priority_arbiter.sv
// Four-requester arbiter: highest effective priority (base priority plus wait age) wins,
// ties resolved round-robin, and the winner holds the grant until it pulses owner_release.
module priority_arbiter #(
   parameter int AGE_PERIOD = 256,
   parameter int AGE_MAX    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [63:0] prio_bus,
   input  logic        owner_release,
   output logic [3:0]  grant,
   output logic [15:0] grant_prio,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      GRANT
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(AGE_PERIOD - 1);
   localparam logic [7:0]  AGE_LIMIT = 8'(AGE_MAX);

   state_t      state;
   state_t      state_next;
   logic [1:0]  rr;
   logic [1:0]  rr_next;
   logic [3:0]  grant_next;
   logic [15:0] grant_prio_next;

   logic [15:0] wait_cnt [4];
   logic [7:0]  age      [4];
   logic [16:0] eff_sum  [4];
   logic [15:0] eff      [4];

   logic        win_valid;
   logic [1:0]  win_idx;
   logic [15:0] win_prio;

   // The sum keeps a carry bit so a large base priority clamps instead of wrapping.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         eff_sum[i] = {1'b0, prio_bus[16*i +: 16]} + 17'(age[i]);
         eff[i]     = eff_sum[i][16] ? 16'hFFFF : eff_sum[i][15:0];
      end
   end

   // Strict greater-than while walking from rr keeps the earliest tied requester.
   always_comb begin
      logic [1:0] idx;
      idx       = rr;
      win_valid = 1'b0;
      win_idx   = 2'd0;
      win_prio  = 16'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr + 2'(k);
         if (req[idx] && (!win_valid || (eff[idx] > win_prio))) begin
            win_valid = 1'b1;
            win_idx   = idx;
            win_prio  = eff[idx];
         end
      end
   end

   always_comb begin
      state_next      = state;
      grant_next      = grant;
      grant_prio_next = grant_prio;
      rr_next         = rr;
      case (state)
         IDLE: begin
            grant_next = 4'b0000;
            if (req != 4'b0000) begin
               state_next = ARB;
            end
         end
         ARB: begin
            if (win_valid) begin
               state_next      = GRANT;
               grant_next      = 4'b0001 << win_idx;
               grant_prio_next = win_prio;
               rr_next         = win_idx + 2'd1;
            end else begin
               state_next = IDLE;
               grant_next = 4'b0000;
            end
         end
         GRANT: begin
            if (owner_release) begin
               state_next = IDLE;
               grant_next = 4'b0000;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 4'b0000;
         grant_prio <= 16'd0;
         rr         <= 2'd0;
      end else begin
         state      <= state_next;
         grant      <= grant_next;
         grant_prio <= grant_prio_next;
         rr         <= rr_next;
      end
   end

   // A requester ages only while it is actively waiting; dropping req or winning starts it over.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst || !req[i] || grant[i]) begin
            wait_cnt[i] <= 16'd0;
            age[i]      <= 8'd0;
         end else if (wait_cnt[i] >= WAIT_LAST) begin
            wait_cnt[i] <= 16'd0;
            if (age[i] < AGE_LIMIT) begin
               age[i] <= age[i] + 8'd1;
            end
         end else begin
            wait_cnt[i] <= wait_cnt[i] + 16'd1;
         end
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench: one arbiter with default aging and one with AGE_PERIOD=4 share all inputs,
// so short scenarios see no aging on the first while the second exposes age arithmetic.
module tb_priority_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] prio_bus;
   logic        rel;

   logic [3:0]  grant_d;
   logic [15:0] prio_d;
   logic        busy_d;
   logic [3:0]  grant_a;
   logic [15:0] prio_a;
   logic        busy_a;

   int vectors;
   int miscompares;

   priority_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .prio_bus      (prio_bus),
      .owner_release (rel),
      .grant         (grant_d),
      .grant_prio    (prio_d),
      .busy          (busy_d)
   );

   priority_arbiter #(.AGE_PERIOD(4), .AGE_MAX(255)) dut_aged (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .prio_bus      (prio_bus),
      .owner_release (rel),
      .grant         (grant_a),
      .grant_prio    (prio_a),
      .busy          (busy_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] packPrio(input logic [15:0] p0, input logic [15:0] p1,
                                            input logic [15:0] p2, input logic [15:0] p3);
      return {p3, p2, p1, p0};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic rl);
      req = r;
      rel = rl;
   endtask

   // Inputs change and outputs are sampled only on the falling edge.
   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      req         = 4'b0000;
      prio_bus    = 64'd0;
      rel         = 1'b0;
      stepCycles(2);
      checkOutput("rst_grant", grant_d, 32'h0);
      checkOutput("rst_busy", busy_d, 32'h0);
      checkOutput("rst_prio", prio_d, 32'h0);
      checkOutput("rst_grant_aged", grant_a, 32'h0);
      rst = 1'b0;

      prio_bus = packPrio(16'd5, 16'd900, 16'd900, 16'd40);
      applyStimulus(4'b1111, 1'b0);
      stepCycles(1);
      checkOutput("arb_grant", grant_d, 32'h0);
      checkOutput("arb_busy", busy_d, 32'h0);
      stepCycles(1);
      checkOutput("max_grant", grant_d, 32'h2);
      checkOutput("max_prio", prio_d, 32'd900);
      checkOutput("max_busy", busy_d, 32'h1);
      applyStimulus(4'b1111, 1'b1);
      stepCycles(1);
      checkOutput("rel_grant", grant_d, 32'h0);
      checkOutput("rel_busy", busy_d, 32'h0);
      applyStimulus(4'b1111, 1'b0);
      stepCycles(2);
      checkOutput("rr2_grant", grant_d, 32'h4);
      checkOutput("rr2_prio", prio_d, 32'd900);
      applyStimulus(4'b1111, 1'b1);
      stepCycles(1);
      applyStimulus(4'b1111, 1'b0);
      stepCycles(2);
      checkOutput("rr3_grant", grant_d, 32'h2);

      rst = 1'b1;
      applyStimulus(4'b1111, 1'b1);
      stepCycles(1);
      checkOutput("midrst_grant", grant_d, 32'h0);
      checkOutput("midrst_busy", busy_d, 32'h0);
      checkOutput("midrst_prio", prio_d, 32'h0);
      rst = 1'b0;
      prio_bus = packPrio(16'd50, 16'd50, 16'd50, 16'd50);
      applyStimulus(4'b1111, 1'b0);
      stepCycles(2);
      checkOutput("tie_grant", grant_d, 32'h1);
      checkOutput("tie_prio", prio_d, 32'd50);
      applyStimulus(4'b0000, 1'b1);
      stepCycles(1);
      applyStimulus(4'b0000, 1'b0);

      prio_bus = packPrio(16'd0, 16'd0, 16'd100, 16'd0);
      applyStimulus(4'b0100, 1'b0);
      stepCycles(1);
      checkOutput("single_arb_grant", grant_d, 32'h0);
      stepCycles(1);
      checkOutput("single_grant", grant_d, 32'h4);
      checkOutput("single_prio", prio_d, 32'd100);
      checkOutput("single_busy", busy_d, 32'h1);
      applyStimulus(4'b0000, 1'b0);
      stepCycles(2);
      checkOutput("hold_grant", grant_d, 32'h4);
      checkOutput("hold_busy", busy_d, 32'h1);
      applyStimulus(4'b0000, 1'b1);
      stepCycles(1);
      checkOutput("single_rel_grant", grant_d, 32'h0);
      checkOutput("single_rel_busy", busy_d, 32'h0);
      checkOutput("single_rel_prio", prio_d, 32'd100);
      applyStimulus(4'b0000, 1'b0);

      prio_bus = packPrio(16'd7, 16'd0, 16'd0, 16'd0);
      applyStimulus(4'b0001, 1'b0);
      stepCycles(1);
      applyStimulus(4'b0001, 1'b1);
      stepCycles(1);
      checkOutput("arbrel_grant", grant_d, 32'h1);
      checkOutput("arbrel_prio", prio_d, 32'd7);
      applyStimulus(4'b0000, 1'b0);
      stepCycles(1);
      checkOutput("arbrel_hold", grant_d, 32'h1);
      applyStimulus(4'b0000, 1'b1);
      stepCycles(1);
      applyStimulus(4'b0000, 1'b0);

      applyStimulus(4'b1000, 1'b0);
      stepCycles(1);
      applyStimulus(4'b0000, 1'b0);
      stepCycles(1);
      checkOutput("wd_grant", grant_d, 32'h0);
      checkOutput("wd_busy", busy_d, 32'h0);
      stepCycles(1);
      checkOutput("wd_idle_grant", grant_d, 32'h0);

      rst = 1'b1;
      stepCycles(1);
      rst = 1'b0;
      prio_bus = packPrio(16'd10, 16'd0, 16'd0, 16'd1000);
      applyStimulus(4'b1001, 1'b0);
      stepCycles(2);
      checkOutput("age_owner", grant_a, 32'h8);
      stepCycles(37);
      checkOutput("age_hold", grant_a, 32'h8);
      applyStimulus(4'b0001, 1'b1);
      stepCycles(1);
      applyStimulus(4'b0001, 1'b0);
      stepCycles(2);
      checkOutput("age_grant", grant_a, 32'h1);
      checkOutput("age_prio", prio_a, 32'd20);
      checkOutput("age_base_prio", prio_d, 32'd10);

      applyStimulus(4'b0000, 1'b1);
      stepCycles(1);
      applyStimulus(4'b0000, 1'b0);
      prio_bus = packPrio(16'hFFFE, 16'd0, 16'd0, 16'hFFFF);
      applyStimulus(4'b1001, 1'b0);
      stepCycles(2);
      checkOutput("sat_owner_grant", grant_a, 32'h8);
      checkOutput("sat_owner_prio", prio_a, 32'hFFFF);
      stepCycles(9);
      applyStimulus(4'b0001, 1'b1);
      stepCycles(1);
      applyStimulus(4'b0001, 1'b0);
      stepCycles(2);
      checkOutput("sat_grant", grant_a, 32'h1);
      checkOutput("sat_prio", prio_a, 32'hFFFF);
      checkOutput("sat_base_prio", prio_d, 32'hFFFE);
      applyStimulus(4'b0000, 1'b1);
      stepCycles(1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("end_busy_aged", busy_a, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
